// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump master.
// Holds the default register-file geometry, which the CPU register file
// also uses, and the dump FSM state encoding.
package regfile_dump_pkg;

  localparam int RF_NUM_REGS   = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: read-side master for the CPU register file debug path.
// A start pulse walks addresses 0..NUM_REGS-1 through one combinational
// read port. Each word is captured and streamed out as a tagged beat on a
// valid/ready interface. The block drives the read address only and never
// writes the register file.
//
// Optional build macro: REGFILE_DUMP_CHECKSUM_EN
//   When defined, an XOR checksum of all words is appended as one extra
//   beat with out_csum=1, and that beat carries out_last instead of the
//   final register beat.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      single-cycle dump request, honoured only in IDLE
//   rd_addr    register-file read address
//   rd_data    combinational read data for rd_addr
//   out_valid  beat present on out_data/out_addr/out_last/out_csum
//   out_ready  consumer accepts the beat at a clk edge while out_valid=1
//   out_data   captured register word, or the checksum
//   out_addr   register index of out_data (0 for the checksum beat)
//   out_last   final beat of the dump
//   out_csum   beat is the checksum word
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final beat is accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; read address parked at 0
// READ  | drive rd_addr=idx, capture rd_data into the output beat
// SEND  | present the captured beat until it is accepted
// CSUM  | present the checksum beat (checksum build only)
// DONE  | pulse done for one cycle, then return to IDLE
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  out_csum,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  at_last;

  assign at_last = (idx == LAST_IDX);

  // The read port is only looked at in READ; parking the address at 0
  // elsewhere keeps the register-file mux quiet while idle.
  assign rd_addr = (state == READ) ? idx : '0;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc;
  logic                  csum_q;

  assign out_csum = csum_q;
`else
  assign out_csum = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc       <= '0;
      csum_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end

        READ: begin
          out_data  <= rd_data;
          out_addr  <= idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= at_last;
`endif
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc <= acc ^ out_data;
`endif
            if (!at_last) begin
              out_valid <= 1'b0;
              idx       <= idx + 1'b1;
              state     <= READ;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Fold the word being accepted now straight into the
              // checksum beat; out_valid stays high into CSUM.
              out_data <= acc ^ out_data;
              out_addr <= '0;
              out_last <= 1'b1;
              csum_q   <= 1'b1;
              state    <= CSUM;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end
          end
        end

`ifdef REGFILE_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            csum_q    <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int NR = RF_NUM_REGS;
  localparam int AW = RF_ADDR_WIDTH;
  localparam int DW = RF_DATA_WIDTH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CSUM_BEATS = 1;
`else
  localparam int CSUM_BEATS = 0;
`endif
  localparam int NB = NR + CSUM_BEATS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
    logic          csum;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          out_csum;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [0:NR-1];
  beat_t         exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepted, done_cnt, done_cyc, last_acc, start_cyc, first_valid;

  regfile_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .out_csum  (out_csum),
    .busy      (busy),
    .done      (done)
  );

  // Register-file model: combinational read, r0 hard-wired to zero.
  assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic preload_ramp();
    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i;
  endtask

  task automatic preload_sparse();
    for (int i = 0; i < NR; i++) rf[i] = '0;
    rf[1] = 32'hA5A5_A5A5;
    rf[2] = 32'h0F0F_0F0F;
  endtask

  // Expected beats for a dump of the current rf contents; n limits how
  // many register beats are expected (a dump cut short by reset).
  task automatic push_expected(input int n, input bit do_write);
    logic [DW-1:0] acc, d;
    beat_t b;
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      d = (i == 0) ? '0 : rf[i];
      if (do_write && i == 20) d = 32'hDEAD_BEEF;
      acc = acc ^ d;
      b.data = d;
      b.addr = AW'(i);
      b.last = (i == NR - 1) && (CSUM_BEATS == 0);
      b.csum = 1'b0;
      if (i < n) exp_q.push_back(b);
    end
    if (n >= NR && CSUM_BEATS != 0) begin
      b.data = acc;
      b.addr = '0;
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Runs one dump: pulses start, drives out_ready, applies the scenario
  // actions and scores every accepted beat against exp_q.
  task automatic drive_dump(input bit stall_mode, input bit restart, input bit do_write,
                            input int reset_addr, output bit timed_out);
    logic [3:0]    pat;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    beat_t         e;
    bit            have_prev, done_seen, restarted, written, finished;
    int            tail;
    pat = 4'b1001;
    have_prev = 0; done_seen = 0; restarted = 0; written = 0; finished = 0; tail = 0;
    accepted = 0; done_cnt = 0; done_cyc = -1; last_acc = -1; first_valid = -1;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 600 && !finished; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_seen = 1;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (have_prev) begin
          checks++;
          if (out_data !== pd || out_addr !== pa) begin
            errors++;
            $display("FAIL stall_hold data=%h addr=%0d required data=%h addr=%0d",
                     out_data, out_addr, pd, pa);
          end
        end
        if (out_ready) begin
          accepted++;
          last_acc = cyc + 1;
          have_prev = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat data=%h addr=%0d required no beat", out_data, out_addr);
          end else begin
            e = exp_q.pop_front();
            if ({out_data, out_addr, out_last, out_csum} !== e) begin
              errors++;
              $display("FAIL beat data=%h addr=%0d last=%b csum=%b required data=%h addr=%0d last=%b csum=%b",
                       out_data, out_addr, out_last, out_csum, e.data, e.addr, e.last, e.csum);
            end
          end
        end else begin
          have_prev = 1;
          pd = out_data;
          pa = out_addr;
        end
      end else begin
        have_prev = 0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (rst) begin
        finished = 1;
      end else begin
        if (reset_addr >= 0 && out_valid && out_addr == AW'(reset_addr)) begin
          rst = 1'b1;
          out_ready = 1'b0;
        end else begin
          out_ready = stall_mode ? pat[i % 4] : 1'b1;
        end
        if (restart && !restarted && accepted == 10) begin
          start = 1'b1;
          restarted = 1;
        end
        if (restart && done) start = 1'b1;
        if (do_write && !written && accepted == 3) begin
          rf[20] = 32'hDEAD_BEEF;
          written = 1;
        end
        if (done_seen) tail++;
        if (tail > 12) finished = 1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    timed_out = !(done_seen || rst);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
    end
    checks++;
    if (out_data !== '0 || out_addr !== '0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_data data=%h addr=%0d rd_addr=%0d required 0 0 0", out_data, out_addr, rd_addr);
    end
    checks++;
    if (out_last !== 1'b0 || out_csum !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags last=%b csum=%b required 0 0", out_last, out_csum);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_full_dump();
    bit to;
    preload_ramp();
    push_expected(NR, 0);
    drive_dump(0, 0, 0, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout done never seen"); end
    checks++;
    if (accepted !== NB) begin errors++; $display("FAIL full_count beats=%0d required %0d", accepted, NB); end
    checks++;
    if (first_valid - start_cyc !== 1) begin
      errors++;
      $display("FAIL first_valid_latency got %0d required 1", first_valid - start_cyc);
    end
    checks++;
    if (last_acc - start_cyc !== 2 * NR + CSUM_BEATS) begin
      errors++;
      $display("FAIL dump_cycles got %0d required %0d", last_acc - start_cyc, 2 * NR + CSUM_BEATS);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_acc) begin
      errors++;
      $display("FAIL done_pulse count=%0d at=%0d required count 1 at %0d", done_cnt, done_cyc, last_acc);
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_end busy=%b left=%0d required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    preload_ramp();
    push_expected(NR, 0);
    drive_dump(1, 0, 0, -1, to);
    checks++;
    if (to || accepted !== NB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count timeout=%b beats=%0d left=%0d required 0 %0d 0", to, accepted, exp_q.size(), NB);
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL bp_done count=%0d required 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    bit to;
    preload_ramp();
    push_expected(NR, 0);
    drive_dump(0, 1, 0, -1, to);
    checks++;
    if (to || accepted !== NB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_count timeout=%b beats=%0d left=%0d required 0 %0d 0", to, accepted, exp_q.size(), NB);
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done count=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit to, bad;
    preload_ramp();
    push_expected(5, 0);
    drive_dump(0, 0, 0, 5, to);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
    end
    checks++;
    if (accepted !== 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_beats beats=%0d left=%0d required 5 0", accepted, exp_q.size());
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_quiet activity seen after reset, required none"); end
    push_expected(NR, 0);
    drive_dump(0, 0, 0, -1, to);
    checks++;
    if (to || accepted !== NB || exp_q.size() != 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_redump timeout=%b beats=%0d left=%0d done=%0d required 0 %0d 0 1",
               to, accepted, exp_q.size(), done_cnt, NB);
    end
  endtask

  task automatic test_write_between_beats();
    bit to;
    preload_ramp();
    push_expected(NR, 1);
    drive_dump(0, 0, 1, -1, to);
    checks++;
    if (to || accepted !== NB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_count timeout=%b beats=%0d left=%0d required 0 %0d 0", to, accepted, exp_q.size(), NB);
    end
  endtask

  task automatic test_sparse_checksum();
    bit to;
    preload_sparse();
    push_expected(NR, 0);
    drive_dump(0, 0, 0, -1, to);
    checks++;
    if (to || accepted !== NB || exp_q.size() != 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL sparse_count timeout=%b beats=%0d left=%0d done=%0d required 0 %0d 0 1",
               to, accepted, exp_q.size(), done_cnt, NB);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_write_between_beats();
    test_sparse_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
